// File: rtl/ones_mod_n_detector.sv
// Serial detector: counts qualifying bits modulo MOD and flags each
// bit that completes a nonzero multiple of MOD.
//
// Ports:
//   clk, rst   rising-edge clock, async active-high reset
//   in_valid   qualifies in_bit
//   in_bit     serial data bit
//   sel_zero   0: count ones, 1: count zeros
//   clr        sync clear of all state (wins over in_valid)
//   hit        completing-bit pulse (comb, or +1 cycle if REG_OUT)
//   residue    running count mod MOD
//   seen_any   a qualifying bit was counted since reset/clr
//   hit_count  saturating number of hits since reset/clr
//   hit_sat    hit_count is all-ones
module ones_mod_n_detector #(
  parameter int MOD     = 3,
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0,
  localparam int RW     = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             sel_zero,
  input  logic             clr,
  output logic             hit,
  output logic [RW-1:0]    residue,
  output logic             seen_any,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_sat
);

  logic [RW-1:0]    res_q;
  logic [RW-1:0]    res_d;
  logic             seen_q;
  logic             seen_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             q;
  logic             at_top;
  logic             h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      res_q  <= res_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    q      = in_valid & (in_bit ^ sel_zero);
    at_top = (res_q == RW'(MOD - 1));
    h      = q & at_top & ~clr;
    res_d  = res_q;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (clr) begin
      res_d  = '0;
      seen_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (q) begin
        res_d  = at_top ? '0 : res_q + RW'(1);
        seen_d = 1'b1;
      end
      // Saturate instead of wrapping to zero
      if (h && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic hit_r;
      // h already excludes clr, so a clear also drops this flop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) hit_r <= 1'b0;
        else     hit_r <= h;
      end
      assign hit = hit_r;
    end else begin : g_comb
      assign hit = h;
    end
  endgenerate

  assign residue   = res_q;
  assign seen_any  = seen_q;
  assign hit_count = cnt_q;
  assign hit_sat   = &cnt_q;

endmodule

// File: tb/tb_ones_mod_n_detector.sv
// Randomised self-checking bench for ones_mod_n_detector.
// Three instances share stimulus: (3,8,comb) (5,8,reg) (2,2,comb).
module tb_ones_mod_n_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic sel_zero = 1'b0;
  logic clr = 1'b0;

  logic       hit0, seen0, sat0;
  logic [1:0] res0;
  logic [7:0] cnt0;
  logic       hit1, seen1, sat1;
  logic [2:0] res1;
  logic [7:0] cnt1;
  logic       hit2, seen2, sat2;
  logic [0:0] res2;
  logic [1:0] cnt2;

  int cmp = 0;
  int fail = 0;

  localparam int MD[3] = '{3, 5, 2};
  localparam int CM[3] = '{255, 255, 3};

  // Reference: bits counted since clear and hits since clear
  int n[3];
  int hc[3];
  bit eh[3];
  bit ereg1;
  logic pre_hit0, pre_hit1, pre_hit2;

  always #5 clk = ~clk;

  ones_mod_n_detector #(.MOD(3), .CNT_W(8), .REG_OUT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .sel_zero(sel_zero), .clr(clr), .hit(hit0), .residue(res0),
    .seen_any(seen0), .hit_count(cnt0), .hit_sat(sat0)
  );

  ones_mod_n_detector #(.MOD(5), .CNT_W(8), .REG_OUT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .sel_zero(sel_zero), .clr(clr), .hit(hit1), .residue(res1),
    .seen_any(seen1), .hit_count(cnt1), .hit_sat(sat1)
  );

  ones_mod_n_detector #(.MOD(2), .CNT_W(2), .REG_OUT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .sel_zero(sel_zero), .clr(clr), .hit(hit2), .residue(res2),
    .seen_any(seen2), .hit_count(cnt2), .hit_sat(sat2)
  );

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      n[i] = 0;
      hc[i] = 0;
      eh[i] = 1'b0;
    end
    ereg1 = 1'b0;
  endtask

  // Drive one cycle, snapshot pre-edge hits, advance the model
  task automatic step(input bit v, input bit b,
                      input bit sz, input bit c);
    bit q;
    @(negedge clk);
    in_valid = v;
    in_bit = b;
    sel_zero = sz;
    clr = c;
    #1;
    q = v & (b ^ sz);
    for (int i = 0; i < 3; i++)
      eh[i] = q && !c && ((n[i] + 1) % MD[i] == 0);
    pre_hit0 = hit0;
    pre_hit1 = hit1;
    pre_hit2 = hit2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        n[i] = 0;
        hc[i] = 0;
      end else begin
        if (q) n[i]++;
        if (eh[i] && hc[i] < CM[i]) hc[i]++;
      end
    end
    ereg1 = eh[1];
    #1;
  endtask

  task automatic test_reset();
    cmp++;
    if (res0 !== 2'd0 || seen0 !== 1'b0 || cnt0 !== 8'd0 || sat0 !== 1'b0) begin
      fail++;
      $display("FAIL reset_u0 res=%0d seen=%b cnt=%0d sat=%b want 0",
               res0, seen0, cnt0, sat0);
    end
    cmp++;
    if (res1 !== 3'd0 || hit1 !== 1'b0 || cnt1 !== 8'd0) begin
      fail++;
      $display("FAIL reset_u1 res=%0d hit=%b cnt=%0d want 0", res1, hit1, cnt1);
    end
    cmp++;
    if (res2 !== 1'd0 || hit2 !== 1'b0 || cnt2 !== 2'd0 || sat2 !== 1'b0) begin
      fail++;
      $display("FAIL reset_u2 res=%0d hit=%b cnt=%0d want 0", res2, hit2, cnt2);
    end
  endtask

  task automatic test_basic();
    int want_res[3] = '{1, 2, 0};
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      cmp++;
      if (pre_hit0 !== (k == 2)) begin
        fail++;
        $display("FAIL basic_hit bit%0d got %b want %b", k, pre_hit0, k == 2);
      end
      cmp++;
      if (res0 !== 2'(want_res[k])) begin
        fail++;
        $display("FAIL basic_res bit%0d got %0d want %0d", k, res0, want_res[k]);
      end
    end
    cmp++;
    if (cnt0 !== 8'd1 || seen0 !== 1'b1) begin
      fail++;
      $display("FAIL basic_cnt got %0d/%b want 1/1", cnt0, seen0);
    end
  endtask

  task automatic test_pattern(input bit gaps);
    bit pat[9] = '{1, 0, 1, 0, 0, 1, 1, 1, 1};
    step(0, 0, 0, 1);
    for (int k = 0; k < 9; k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          step(0, 1'($urandom), 0, 0);
          cmp++;
          if (pre_hit0 !== 1'b0) begin
            fail++;
            $display("FAIL gap_hit bit%0d got %b want 0", k, pre_hit0);
          end
        end
      end
      step(1, pat[k], 0, 0);
      cmp++;
      if (pre_hit0 !== (k == 5 || k == 8)) begin
        fail++;
        $display("FAIL pattern_hit gaps=%b bit%0d got %b want %b",
                 gaps, k, pre_hit0, (k == 5 || k == 8));
      end
    end
    cmp++;
    if (cnt0 !== 8'd2) begin
      fail++;
      $display("FAIL pattern_cnt gaps=%b got %0d want 2", gaps, cnt0);
    end
  endtask

  task automatic test_regout();
    logic prev = 1'b0;
    step(0, 0, 0, 1);
    for (int k = 0; k < 11; k++) begin
      step(k < 10, 1, 0, 0);
      cmp++;
      if (hit1 !== (k == 4 || k == 9)) begin
        fail++;
        $display("FAIL regout_hit after bit%0d got %b want %b",
                 k, hit1, (k == 4 || k == 9));
      end
      cmp++;
      if (prev === 1'b1 && hit1 === 1'b1) begin
        fail++;
        $display("FAIL regout_pulse cycle%0d got 11 want single", k);
      end
      prev = hit1;
    end
    cmp++;
    if (cnt1 !== 8'd2) begin
      fail++;
      $display("FAIL regout_cnt got %0d want 2", cnt1);
    end
  endtask

  task automatic test_sel_zero();
    bit pat[4] = '{0, 0, 1, 0};
    logic [1:0] r;
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, pat[k], 1, 0);
      cmp++;
      if (pre_hit0 !== (k == 3)) begin
        fail++;
        $display("FAIL selzero_hit bit%0d got %b want %b", k, pre_hit0, k == 3);
      end
    end
    step(1, 0, 1, 0);
    r = res0;
    step(0, 0, 0, 0);
    cmp++;
    if (res0 !== r || res0 !== 2'd1) begin
      fail++;
      $display("FAIL selzero_toggle got %0d want 1", res0);
    end
    step(1, 1, 0, 0);
    cmp++;
    if (res0 !== 2'd2) begin
      fail++;
      $display("FAIL selzero_ones got %0d want 2", res0);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 0, 0);
      cmp++;
      if (pre_hit2 !== (k % 2 == 1)) begin
        fail++;
        $display("FAIL sat_hit bit%0d got %b want %b", k, pre_hit2, k % 2 == 1);
      end
      cmp++;
      if (cnt2 !== 2'(hc[2]) || sat2 !== (hc[2] == 3)) begin
        fail++;
        $display("FAIL sat_cnt bit%0d got %0d/%b want %0d/%b",
                 k, cnt2, sat2, hc[2], hc[2] == 3);
      end
    end
    cmp++;
    if (cnt2 !== 2'd3 || sat2 !== 1'b1) begin
      fail++;
      $display("FAIL sat_final got %0d/%b want 3/1", cnt2, sat2);
    end
  endtask

  task automatic test_clr_on_hit();
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    cmp++;
    if (pre_hit0 !== 1'b0) begin
      fail++;
      $display("FAIL clrhit_hit got %b want 0", pre_hit0);
    end
    cmp++;
    if (res0 !== 2'd0 || seen0 !== 1'b0 || cnt0 !== 8'd0 || hit1 !== 1'b0) begin
      fail++;
      $display("FAIL clrhit_state res=%0d seen=%b cnt=%0d h1=%b want 0",
               res0, seen0, cnt0, hit1);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    cmp++;
    if (res0 !== 2'd2) begin
      fail++;
      $display("FAIL arst_pre got %0d want 2", res0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp++;
    if (res0 !== 2'd0 || seen0 !== 1'b0 || hit0 !== 1'b0 ||
        res1 !== 3'd0 || cnt2 !== 2'd0) begin
      fail++;
      $display("FAIL arst_async res0=%0d seen0=%b hit0=%b res1=%0d want 0",
               res0, seen0, hit0, res1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    step(1, 1, 0, 0);
    cmp++;
    if (res0 !== 2'd1 || seen0 !== 1'b1) begin
      fail++;
      $display("FAIL arst_resume got %0d/%b want 1/1", res0, seen0);
    end
  endtask

  task automatic test_random();
    bit sz = 1'b0;
    step(0, 0, 0, 1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) sz = ~sz;
      step($urandom_range(0, 3) != 0, 1'($urandom), sz,
           $urandom_range(0, 49) == 0);
      cmp++;
      if (pre_hit0 !== eh[0] || pre_hit2 !== eh[2] || hit1 !== ereg1) begin
        fail++;
        $display("FAIL rand_hit step%0d got %b%b%b want %b%b%b",
                 k, pre_hit0, hit1, pre_hit2, eh[0], ereg1, eh[2]);
      end
      cmp++;
      if (res0 !== 2'(n[0] % 3) || res1 !== 3'(n[1] % 5) ||
          res2 !== 1'(n[2] % 2)) begin
        fail++;
        $display("FAIL rand_res step%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, res0, res1, res2, n[0] % 3, n[1] % 5, n[2] % 2);
      end
      cmp++;
      if (seen0 !== (n[0] != 0) || seen1 !== (n[1] != 0) ||
          seen2 !== (n[2] != 0)) begin
        fail++;
        $display("FAIL rand_seen step%0d got %b%b%b", k, seen0, seen1, seen2);
      end
      cmp++;
      if (cnt0 !== 8'(hc[0]) || cnt1 !== 8'(hc[1]) || cnt2 !== 2'(hc[2]) ||
          sat2 !== (hc[2] == 3) || sat0 !== (hc[0] == 255)) begin
        fail++;
        $display("FAIL rand_cnt step%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, cnt0, cnt1, cnt2, hc[0], hc[1], hc[2]);
      end
    end
  endtask

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_pattern(1'b0);
    test_pattern(1'b1);
    test_regout();
    test_sel_zero();
    test_saturate();
    test_clr_on_hit();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end

endmodule
